// File: rtl/two_to_four_sequenced_decoder_module.sv
// Buffers 2-bit encoded codes in a small FIFO and replays each one as a
// registered one-hot line held for HOLD cycles, with a 1-cycle zero gap
// between consecutive codes.
module two_to_four_sequenced_decoder_module #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_code,
  output logic [3:0]               out_onehot,
  output logic                     out_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     stall_seen
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(HOLD) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      onehot_q, onehot_d;
  logic            valid_q, valid_d;
  logic            stall_q;
  logic            push, pop;
  logic [1:0]      head_code;

  // Ready depends only on registered occupancy, so a full FIFO refuses a
  // push even when the FSM pops on the same edge.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign head_code = mem[rd_ptr_q];

  assign out_onehot = onehot_q;
  assign out_valid  = valid_q;
  assign count      = count_q;
  assign stall_seen = stall_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

  // FIFO storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_code;
    end
  end

  // FIFO pointers and occupancy; pointer width makes wrap modulo DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flag for an offered code that was refused.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= 1'b0;
    end else if (in_valid && !in_ready) begin
      stall_q <= 1'b1;
    end
  end

  // FSM state, hold timer and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state logic: pop and load from IDLE or GAP, count down in DRIVE.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    pop      = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        onehot_d = '0;
        valid_d  = 1'b0;
        if (count_q != '0) begin
          pop      = 1'b1;
          onehot_d = 4'b0001 << head_code;
          valid_d  = 1'b1;
          timer_d  = TW'(HOLD - 1);
          state_d  = DRIVE;
        end else begin
          state_d  = IDLE;
        end
      end
      DRIVE: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          onehot_d = '0;
          valid_d  = 1'b0;
          state_d  = GAP;
        end
      end
      default: begin
        onehot_d = '0;
        valid_d  = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_two_to_four_sequenced_decoder_module.sv
// Directed self-checking bench for the sequenced 2:4 decoder (DEPTH=4, HOLD=3).
module tb_two_to_four_sequenced_decoder_module;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_code;
  logic [3:0] out_onehot;
  logic       out_valid;
  logic       busy;
  logic [2:0] count;
  logic       stall_seen;

  int tests;
  int fails;
  logic [1:0] sbq[$];
  logic       prev_valid;
  int         max_count;
  logic       saw_not_ready;

  two_to_four_sequenced_decoder_module #(
    .DEPTH(4),
    .HOLD (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_onehot(out_onehot),
    .out_valid (out_valid),
    .busy      (busy),
    .count     (count),
    .stall_seen(stall_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with scoreboard bookkeeping: record an accepted code, then
  // after the edge check the one-hot invariant and each newly shown code.
  task automatic sb_cycle();
    logic [1:0] e;
    if (in_valid && in_ready) sbq.push_back(in_code);
    tick();
    chk("onehot0", 32'($onehot0(out_onehot)), 32'd1);
    chk("valid_vs_line", 32'(out_valid), 32'(out_onehot != 4'b0000));
    if (int'(count) > max_count) max_count = int'(count);
    if (!in_ready) saw_not_ready = 1'b1;
    if (out_valid && !prev_valid) begin
      if (sbq.size() == 0) begin
        chk("sb_extra_out", 32'(out_onehot), 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("sb_order", 32'(out_onehot), 32'(4'b0001 << e));
      end
    end
    prev_valid = out_valid;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((busy || sbq.size() != 0) && n < 200) begin
      sb_cycle();
      n++;
    end
    chk({tag, "_drain_timeout"}, 32'(n < 200), 32'd1);
    chk({tag, "_sb_empty"}, 32'(sbq.size()), 32'd0);
  endtask

  logic [3:0] exp3 [10];

  initial begin
    tests = 0;
    fails = 0;
    prev_valid = 1'b0;
    max_count = 0;
    saw_not_ready = 1'b0;

    // 1: reset with random inputs
    reset_n  = 1'b0;
    in_valid = 1'($urandom_range(0, 1));
    in_code  = 2'($urandom_range(0, 3));
    #3;
    chk("rst_onehot", 32'(out_onehot), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_code  = 2'($urandom_range(0, 3));
    end
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_stall", 32'(stall_seen), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    tick();
    tick();
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_onehot", 32'(out_onehot), 32'h0);

    // 2: single code 2'b10
    in_valid = 1'b1;
    in_code  = 2'b10;
    tick();                                   // edge N
    in_valid = 1'b0;
    chk("t2_count_N", 32'(count), 32'd1);
    chk("t2_onehot_N", 32'(out_onehot), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();                                 // edges N+1..N+3
      chk("t2_onehot_hold", 32'(out_onehot), 32'h4);
      chk("t2_valid_hold", 32'(out_valid), 32'h1);
    end
    tick();                                   // N+4
    chk("t2_onehot_gap", 32'(out_onehot), 32'h0);
    chk("t2_valid_gap", 32'(out_valid), 32'h0);
    chk("t2_busy_gap", 32'(busy), 32'h1);
    tick();                                   // N+5
    chk("t2_busy_end", 32'(busy), 32'h0);

    // 3: 2'b00 then 2'b11 back to back
    exp3[0] = 4'b0000;
    exp3[1] = 4'b0001; exp3[2] = 4'b0001; exp3[3] = 4'b0001;
    exp3[4] = 4'b0000;
    exp3[5] = 4'b1000; exp3[6] = 4'b1000; exp3[7] = 4'b1000;
    exp3[8] = 4'b0000; exp3[9] = 4'b0000;
    max_count = 0;
    in_valid = 1'b1;
    in_code  = 2'b00;
    tick();
    if (int'(count) > max_count) max_count = int'(count);
    chk("t3_seq", 32'(out_onehot), 32'(exp3[0]));
    in_code = 2'b11;
    for (int i = 1; i < 10; i++) begin
      tick();
      in_valid = 1'b0;
      if (int'(count) > max_count) max_count = int'(count);
      chk("t3_seq", 32'(out_onehot), 32'(exp3[i]));
    end
    chk("t3_count_peak", 32'(max_count), 32'd1);
    chk("t3_busy_end", 32'(busy), 32'h0);

    // 4: continuous offer, FIFO fills, stall becomes sticky
    max_count = 0;
    saw_not_ready = 1'b0;
    prev_valid = out_valid;
    chk("t4_stall_before", 32'(stall_seen), 32'h0);
    for (int i = 0; i < 24; i++) begin
      in_valid = 1'b1;
      in_code  = 2'(i % 4);
      sb_cycle();
    end
    chk("t4_count_max", 32'(max_count), 32'd4);
    chk("t4_not_ready_seen", 32'(saw_not_ready), 32'd1);
    chk("t4_stall_set", 32'(stall_seen), 32'h1);
    drain("t4");
    chk("t4_stall_sticky", 32'(stall_seen), 32'h1);

    // 5: asynchronous reset mid-DRIVE with three codes buffered
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_code  = 2'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("t5_count_pre", 32'(count), 32'd3);
    chk("t5_valid_pre", 32'(out_valid), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_onehot", 32'(out_onehot), 32'h0);
    chk("t5_async_count", 32'(count), 32'h0);
    chk("t5_async_stall", 32'(stall_seen), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    in_valid = 1'b1;
    in_code  = 2'b01;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t5_after_reset", 32'(out_onehot), 32'h2);
    prev_valid = out_valid;
    drain("t5");

    // 6: random streams against the scoreboard
    for (int s = 0; s < 16; s++) begin
      int len;
      len = int'($urandom_range(1, 8));
      prev_valid = out_valid;
      for (int k = 0; k < len; k++) begin
        in_valid = 1'($urandom_range(0, 1));
        in_code  = 2'($urandom_range(0, 3));
        sb_cycle();
      end
      drain("t6");
    end
    chk("t6_idle_end", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
